// File: rtl/ivd_pkg.sv
// Shared types for the IVD readout sequencer.
//   ivd_state_e  : sequencer FSM states
//   ivd_result_t : one per-channel result (channel, average, positive call).
//                  Fields use the widest supported sizes (64 channels, 32-bit samples).
//                  Instances narrow them to the configured widths.
package ivd_pkg;

  localparam int unsigned IVD_CH_W_MAX  = 6;
  localparam int unsigned IVD_AVG_W_MAX = 32;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StAccum,
    StEmit,
    StDone
  } ivd_state_e;

  typedef struct packed {
    logic [IVD_CH_W_MAX-1:0]  ch;
    logic [IVD_AVG_W_MAX-1:0] avg;
    logic                     pos;
  } ivd_result_t;

endpackage

// File: rtl/ivd_sample_accum.sv
// Sample accumulator for one channel: sums 2^ACC_LOG2 ADC samples and reports their average.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   clr                : clear accumulator and sample count
//   en                 : accumulation window open
//   smp_valid/smp_data : ADC sample strobe and value
//   full               : the sample accepted this cycle completes the set
//   avg                : truncated average including this cycle's sample (valid while full=1)
module ivd_sample_accum
  import ivd_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned ACC_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                smp_valid,
  input  logic [SAMPLE_W-1:0] smp_data,
  output logic                full,
  output logic [SAMPLE_W-1:0] avg
);

  localparam int unsigned ACC_W = SAMPLE_W + ACC_LOG2;
  localparam int unsigned CNT_W = ACC_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((2 ** ACC_LOG2) - 1);

  logic [ACC_W-1:0] acc_q, acc_sum;
  logic [CNT_W-1:0] cnt_q;
  logic             take;

  assign take    = en & smp_valid;
  assign acc_sum = acc_q + ACC_W'(smp_data);

  // Flag completion on the last sample itself so the result can be latched the same edge.
  assign full = take && (cnt_q == LAST);
  assign avg  = acc_sum[ACC_W-1:ACC_LOG2];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (take) begin
      acc_q <= acc_sum;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ivd_readout_sequencer.sv
// Detector readout sequencer: scans N_CH channels, settles the analog mux, averages
// 2^ACC_LOG2 ADC samples per channel and emits a thresholded result per channel on a
// valid/ready stream. One scan per start pulse.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : scan request (sampled in idle only)
//   cal                      : (IVD_READOUT_BASELINE_EN only) start a calibration scan
//   busy, done               : scan in progress / one-cycle completion pulse
//   sel_ch                   : analog mux channel select
//   smp_valid, smp_data      : ADC sample stream
//   res_valid, res_ready     : result handshake
//   res_ch, res_avg, res_pos : result channel, average, positive call
// Build option: define IVD_READOUT_BASELINE_EN to add per-channel baseline calibration and
// subtraction; without it the raw average is reported.
module ivd_readout_sequencer
  import ivd_pkg::*;
#(
  parameter int unsigned          N_CH       = 12,
  parameter int unsigned          SAMPLE_W   = 12,
  parameter int unsigned          ACC_LOG2   = 4,
  parameter int unsigned          SETTLE_CYC = 8,
  parameter logic [SAMPLE_W-1:0]  THRESH     = 12'd2048,
  localparam int unsigned         CH_W       = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
`ifdef IVD_READOUT_BASELINE_EN
  input  logic                cal,
`endif
  output logic                busy,
  output logic                done,
  output logic [CH_W-1:0]     sel_ch,
  input  logic                smp_valid,
  input  logic [SAMPLE_W-1:0] smp_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CH_W-1:0]     res_ch,
  output logic [SAMPLE_W-1:0] res_avg,
  output logic                res_pos
);

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  ivd_state_e          state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [SET_W-1:0]    set_q, set_d;
  ivd_result_t         res_q, res_d;
  logic                last_ch, set_last, full, cal_scan;
  logic [SAMPLE_W-1:0] raw_avg, adj_avg;

  assign last_ch  = (ch_q == CH_W'(N_CH - 1));
  assign set_last = (set_q == SET_W'(SETTLE_CYC - 1));

  ivd_sample_accum #(
    .SAMPLE_W (SAMPLE_W),
    .ACC_LOG2 (ACC_LOG2)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == StSettle),
    .en        (state_q == StAccum),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .full      (full),
    .avg       (raw_avg)
  );

`ifdef IVD_READOUT_BASELINE_EN
  logic                cal_q;
  logic [SAMPLE_W-1:0] base_q [N_CH];
  logic [SAMPLE_W-1:0] base;

  assign cal_scan = cal_q;
  assign base     = base_q[ch_q];
  // Saturate at zero so a channel reading below its baseline reports 0, not a wrapped value.
  assign adj_avg  = (raw_avg >= base) ? (raw_avg - base) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cal_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      cal_q <= cal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        base_q[i] <= '0;
      end
    end else if (state_q == StAccum && full && cal_q) begin
      base_q[ch_q] <= raw_avg;
    end
  end
`else
  assign cal_scan = 1'b0;
  assign adj_avg  = raw_avg;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StSettle;
      StSettle: if (set_last) state_d = StAccum;
      StAccum: begin
        if (full) begin
          // Calibration scans store the baseline and skip the result handshake.
          if (cal_scan) state_d = last_ch ? StDone : StSettle;
          else          state_d = StEmit;
        end
      end
      StEmit:   if (res_ready) state_d = last_ch ? StDone : StSettle;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    busy      = 1'b1;
    done      = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      StIdle:  busy      = 1'b0;
      StEmit:  res_valid = 1'b1;
      StDone:  done      = 1'b1;
      default: ;
    endcase
  end

  // Channel, settle counter and result register.
  always_comb begin
    ch_d  = ch_q;
    set_d = '0;
    res_d = res_q;
    case (state_q)
      StIdle:   if (start) ch_d = '0;
      StSettle: if (!set_last) set_d = set_q + SET_W'(1);
      StAccum: begin
        if (full) begin
          if (cal_scan) begin
            if (!last_ch) ch_d = ch_q + CH_W'(1);
          end else begin
            res_d.ch  = IVD_CH_W_MAX'(ch_q);
            res_d.avg = IVD_AVG_W_MAX'(adj_avg);
            res_d.pos = (adj_avg >= THRESH);
          end
        end
      end
      StEmit:   if (res_ready && !last_ch) ch_d = ch_q + CH_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q  <= '0;
      set_q <= '0;
      res_q <= '0;
    end else begin
      ch_q  <= ch_d;
      set_q <= set_d;
      res_q <= res_d;
    end
  end

  assign sel_ch  = ch_q;
  assign res_ch  = res_q.ch[CH_W-1:0];
  assign res_avg = res_q.avg[SAMPLE_W-1:0];
  assign res_pos = res_q.pos;

  // Upper struct bits beyond the configured widths are intentionally dropped.
  logic unused_res;
  assign unused_res = ^res_q;

endmodule

// File: tb/tb_ivd_readout_sequencer.sv
// Self-checking bench for ivd_readout_sequencer (default parameters).
// Define IVD_READOUT_BASELINE_EN to also exercise the calibration/baseline scans.
module tb_ivd_readout_sequencer;

  localparam int unsigned N_CH       = 12;
  localparam int unsigned SAMPLE_W   = 12;
  localparam int unsigned ACC_LOG2   = 4;
  localparam int unsigned SETTLE_CYC = 8;
  localparam int unsigned CH_W       = $clog2(N_CH);
  localparam int          NSMP       = 1 << ACC_LOG2;
  localparam int          THR        = 2048;

  logic                clk = 1'b0;
  logic                rst, start, cal, smp_valid, res_ready;
  logic [SAMPLE_W-1:0] smp_data;
  logic                busy, done, res_valid, res_pos;
  logic [CH_W-1:0]     sel_ch, res_ch;
  logic [SAMPLE_W-1:0] res_avg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ivd_readout_sequencer #(
    .N_CH       (N_CH),
    .SAMPLE_W   (SAMPLE_W),
    .ACC_LOG2   (ACC_LOG2),
    .SETTLE_CYC (SETTLE_CYC),
    .THRESH     (12'd2048)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef IVD_READOUT_BASELINE_EN
    .cal       (cal),
`endif
    .busy      (busy),
    .done      (done),
    .sel_ch    (sel_ch),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_ch    (res_ch),
    .res_avg   (res_avg),
    .res_pos   (res_pos)
  );

  // Model: expected results in emission order, plus the baseline each channel has learned.
  typedef struct {
    int ch;
    int avg;
    bit pos;
  } exp_t;

  exp_t exp_q[$];
  int   base[N_CH];

  // Stimulus knobs.
  int pat_mode, pat_a, pat_b;
  bit settle_junk, gaps, start_noise;
  int stall_ch, stall_n;
  int pin_avg, pin_pos;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sample_val(input int c, input int k);
    case (pat_mode)
      0:       return pat_a;
      1:       return (k % 2 == 0) ? pat_a : pat_b;
      default: return (pat_a + 100 * c + 37 * k) % 4096;
    endcase
  endfunction

  function automatic int raw_for(input int c);
    int sum;
    sum = 0;
    for (int k = 0; k < NSMP; k++) sum += sample_val(c, k);
    return sum / NSMP;
  endfunction

  function automatic exp_t expect_for(input int c);
    exp_t e;
    int   raw;
    raw   = raw_for(c);
    e.ch  = c;
    e.avg = (raw >= base[c]) ? raw - base[c] : 0;
    e.pos = (e.avg >= THR);
    return e;
  endfunction

  // Per-cycle compare of the result stream against the model queue.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_res", 1, 0);
        end else begin
          check("res_ch", res_ch, exp_q[0].ch);
          check("res_avg", res_avg, exp_q[0].avg);
          check("res_pos", res_pos, exp_q[0].pos);
          if (res_ready) void'(exp_q.pop_front());
        end
      end
      if (done === 1'b1) check("done_with_pending", exp_q.size(), 0);
    end
  end

  // One full scan following the specified cycle timing. abort_ch >= 0 resets mid-ACCUM there.
  task automatic scan(input bit is_cal, input int abort_ch);
    int k, slot;
    cal   = is_cal;
    start = 1'b1;
    tick();
    start = 1'b0;
    cal   = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      for (int s = 0; s < SETTLE_CYC; s++) begin
        if (s == 0) begin
          check("busy_settle", busy, 1);
          check("sel_ch_settle", sel_ch, c);
        end
        start     = start_noise && (s == 2);
        smp_valid = settle_junk;
        smp_data  = 12'd4095;
        tick();
      end
      start = 1'b0;
      k     = 0;
      slot  = 0;
      while (k < NSMP) begin
        if (c == abort_ch && k == 5) begin
          smp_valid = 1'b0;
          rst       = 1'b1;
          tick();
          rst = 1'b0;
          exp_q.delete();
          check("rst_busy", busy, 0);
          check("rst_res_valid", res_valid, 0);
          check("rst_sel_ch", sel_ch, 0);
          check("rst_done", done, 0);
          return;
        end
        if (gaps && slot % 3 == 2) begin
          smp_valid = 1'b0;
          smp_data  = 12'd4095;
        end else begin
          smp_valid = 1'b1;
          smp_data  = SAMPLE_W'(sample_val(c, k));
          k++;
        end
        slot++;
        tick();
      end
      smp_valid = 1'b0;
      smp_data  = '0;
      if (is_cal) begin
        base[c] = raw_for(c);
        check("cal_no_res", res_valid, 0);
        continue;
      end
      exp_q.push_back(expect_for(c));
      check("res_valid_timing", res_valid, 1);
      if (c == 0 && pin_avg >= 0) begin
        check("pin_avg", res_avg, pin_avg);
        check("pin_pos", res_pos, pin_pos);
      end
      if (c == stall_ch) begin
        for (int w = 0; w < stall_n; w++) begin
          res_ready = 1'b0;
          tick();
          check("stall_sel_ch", sel_ch, c);
          check("stall_valid", res_valid, 1);
        end
      end
      res_ready = 1'b1;
      tick();
    end
    check("done_pulse", done, 1);
    tick();
    check("done_low", done, 0);
    check("busy_idle", busy, 0);
    check("all_results", exp_q.size(), 0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    cal         = 1'b0;
    smp_valid   = 1'b0;
    smp_data    = '0;
    res_ready   = 1'b1;
    pat_mode    = 0;
    pat_a       = 0;
    pat_b       = 0;
    settle_junk = 1'b0;
    gaps        = 1'b0;
    start_noise = 1'b0;
    stall_ch    = -1;
    stall_n     = 0;
    pin_avg     = -1;
    pin_pos     = 0;
    for (int i = 0; i < N_CH; i++) base[i] = 0;

    tick();
    tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sel_ch", sel_ch, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_res_ch", res_ch, 0);
    check("reset_res_avg", res_avg, 0);
    check("reset_res_pos", res_pos, 0);
    rst = 1'b0;
    tick();

    // Constant 3000 on every channel.
    pat_mode = 0; pat_a = 3000; pin_avg = 3000; pin_pos = 1;
    scan(1'b0, -1);

    // Alternating 2047/2048 truncates to 2047, just below threshold.
    pat_mode = 1; pat_a = 2047; pat_b = 2048; pin_avg = 2047; pin_pos = 0;
    scan(1'b0, -1);

    // Exactly at threshold, with a 5-cycle consumer stall on channel 3.
    pat_mode = 0; pat_a = 2048; pin_avg = 2048; pin_pos = 1;
    stall_ch = 3; stall_n = 5;
    scan(1'b0, -1);
    stall_ch = -1; stall_n = 0;

    // Junk samples during settle, gapped sample strobes, start pulses while busy.
    pat_mode = 0; pat_a = 100; pin_avg = 100; pin_pos = 0;
    settle_junk = 1'b1; gaps = 1'b1; start_noise = 1'b1;
    scan(1'b0, -1);
    settle_junk = 1'b0; gaps = 1'b0; start_noise = 1'b0;

    // Per-channel ramp: reset mid-ACCUM on channel 5, then a full restart from channel 0.
    pat_mode = 2; pat_a = 1000; pin_avg = 1000 + (37 * 15) / 2; pin_pos = 0;
    scan(1'b0, 5);
    tick();
    scan(1'b0, -1);

`ifdef IVD_READOUT_BASELINE_EN
    // Calibrate at 500, then measure above and below the baseline.
    pat_mode = 0; pat_a = 500; pin_avg = -1;
    scan(1'b1, -1);
    pat_a = 2600; pin_avg = 2100; pin_pos = 1;
    scan(1'b0, -1);
    pat_a = 400; pin_avg = 0; pin_pos = 0;
    scan(1'b0, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
